// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl
//   Upstream sequencer for a tri-state driver bank on main_bus. CPU writes
//   are buffered in a small FIFO and replayed as bus write cycles. A read
//   releases the bus, waits a turnaround and samples main_bus.
//
// Handshakes: a write is accepted on a posedge where wr_valid && wr_ready;
//   a read is accepted on a posedge where rd_req && rd_ready. A request
//   presented while its ready is low is dropped, never queued. rd_valid is
//   a one-cycle pulse that qualifies rd_data; it has no back-pressure.
//
// Ports
//   myclk       clock, all state on posedge
//   reset       asynchronous, active-high reset
//   wr_valid    CPU write request
//   wr_data     CPU write data
//   wr_ready    write FIFO not full
//   rd_req      CPU read request
//   rd_ready    no read pending
//   rd_data     last sampled main_bus value
//   rd_valid    one-cycle pulse, rd_data valid
//   main_bus    bus value, sampled in SAMPLE
//   cpu_bus     registered data to the driver bank
//   read_state  registered; 0 = driver bank drives main_bus (HOLD only)
//   busy        FSM not idle, FIFO non-empty or read pending
//   state_dbg   current FSM state encoding, for debug and checkers
//
// Optional feature: define BUS_CYCLE_CTRL_STATS_EN to add saturating
//   8-bit counters wr_count (bus write cycles started) and rd_count
//   (rd_valid pulses).
module bus_cycle_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             myclk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] main_bus,
  output logic [WIDTH-1:0] cpu_bus,
  output logic             read_state,
  output logic             busy,
  output logic [2:0]       state_dbg
`ifdef BUS_CYCLE_CTRL_STATS_EN
  ,
  output logic [7:0]       wr_count,
  output logic [7:0]       rd_count
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_HOLD   = 3'd2,
    S_TURN   = 3'd3,
    S_SAMPLE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] cpu_bus_q, cpu_bus_d;
  logic             read_state_q, read_state_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, push, pop, rd_accept;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = wr_valid && !full;
  assign rd_accept = rd_req && !pending_q;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    cpu_bus_d  = cpu_bus_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    pending_d  = pending_q || rd_accept;

    case (state_q)
      S_IDLE: begin
        // Queued writes win over a pending read so that every write
        // accepted before the read reaches the bus first.
        if (!empty) begin
          state_d   = S_DRIVE;
          pop       = 1'b1;
          cpu_bus_d = mem_q[rd_ptr_q];
        end else if (pending_q) begin
          state_d = S_TURN;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + CYC_ONE;
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) state_d = S_SAMPLE;
        else                    cnt_d   = cnt_q + CYC_ONE;
      end
      S_SAMPLE: begin
        rd_data_d  = main_bus;
        rd_valid_d = 1'b1;
        pending_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so the enable and the state change
    // on the same edge.
    read_state_d = (state_d != S_HOLD);

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge myclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= 1'b0;
      cpu_bus_q    <= '0;
      read_state_q <= 1'b1;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      cpu_bus_q    <= cpu_bus_d;
      read_state_q <= read_state_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge myclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign wr_ready   = !full;
  assign rd_ready   = !pending_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign cpu_bus    = cpu_bus_q;
  assign read_state = read_state_q;
  assign busy       = (state_q != S_IDLE) || !empty || pending_q;
  assign state_dbg  = state_q;

`ifdef BUS_CYCLE_CTRL_STATS_EN
  logic [7:0] wr_count_q, wr_count_d;
  logic [7:0] rd_count_q, rd_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    // A pop is exactly a DRIVE entry.
    if (pop && (wr_count_q != 8'hFF))        wr_count_d = wr_count_q + 8'd1;
    if (rd_valid_d && (rd_count_q != 8'hFF)) rd_count_d = rd_count_q + 8'd1;
  end

  always_ff @(posedge myclk or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed vector table, hand-written
// fill and mid-HOLD reset sequences, then random traffic against a
// transaction-level reference model. main_bus comes from a driver-bank model
// that drives cpu_bus while read_state is low and bus_ext otherwise.
module tb_bus_cycle_ctrl;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int TURN  = 1;

  // ---------------- clock / reset ----------------
  logic         myclk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_req = 1'b0;
  logic [W-1:0] bus_ext = '0;
  logic         wr_ready, rd_ready, rd_valid, read_state, busy;
  logic [W-1:0] rd_data, cpu_bus, main_bus;
  logic [2:0]   state_dbg;
`ifdef BUS_CYCLE_CTRL_STATS_EN
  logic [7:0]   wr_count, rd_count;
`endif

  always #5 myclk = ~myclk;

  assign main_bus = read_state ? bus_ext : cpu_bus;

  bus_cycle_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TURN_CYCLES(TURN)) dut (
    .myclk(myclk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .main_bus(main_bus), .cpu_bus(cpu_bus), .read_state(read_state),
    .busy(busy), .state_dbg(state_dbg)
`ifdef BUS_CYCLE_CTRL_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];     // writes accepted but not yet put on the bus
  logic [W-1:0] bus_seen[$];  // values observed on main_bus at each HOLD start
  int           e_cnt = 0;    // posedge index
  int           next_decide;  // first edge at which the controller is idle again
  logic         m_pend;
  int           lo_from, lo_to, sample_edge, rdv_edge;
  logic [W-1:0] m_cpu, m_rd;
  logic         prev_rs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_decide = 0;
    m_pend      = 1'b0;
    lo_from     = -1;
    lo_to       = -2;
    sample_edge = -1;
    rdv_edge    = -1;
    m_cpu       = '0;
    m_rd        = '0;
  endtask

  // One posedge at the transaction level: an idle controller starts a
  // write (HOLD+2 cycles) if any are queued, else a pending read
  // (TURN+2 cycles); requests are accepted against pre-edge occupancy.
  task automatic model_edge(input logic wv, input logic [W-1:0] wd,
                            input logic rr, input logic [W-1:0] mb);
    int   pre_cnt;
    logic pre_pend;
    logic idle;
    pre_cnt  = exp_q.size();
    pre_pend = m_pend;
    idle     = (e_cnt >= next_decide);
    if (idle && pre_cnt > 0) begin
      m_cpu       = exp_q.pop_front();
      lo_from     = e_cnt + 1;
      lo_to       = e_cnt + HOLD;
      next_decide = e_cnt + HOLD + 2;
    end else if (idle && pre_pend) begin
      sample_edge = e_cnt + TURN + 1;
      next_decide = e_cnt + TURN + 2;
    end
    if (e_cnt == sample_edge) begin
      m_rd     = mb;
      rdv_edge = e_cnt;
      m_pend   = 1'b0;
    end
    if (wv && pre_cnt < DEPTH) exp_q.push_back(wd);
    if (rr && !pre_pend) m_pend = 1'b1;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, run one posedge, check at next negedge.
  task automatic step(input logic wv, input logic [W-1:0] wd,
                      input logic rr, input logic [W-1:0] ext);
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    bus_ext  = ext;
    @(posedge myclk);
    e_cnt++;
    model_edge(wv, wd, rr, ext);
    @(negedge myclk);
    check("m_read_state", read_state, !(e_cnt >= lo_from && e_cnt <= lo_to));
    check("m_cpu_bus",    cpu_bus,    m_cpu);
    check("m_rd_valid",   rd_valid,   (rdv_edge == e_cnt));
    check("m_rd_data",    rd_data,    m_rd);
    check("m_wr_ready",   wr_ready,   (exp_q.size() < DEPTH));
    check("m_rd_ready",   rd_ready,   !m_pend);
    check("m_busy",       busy,       (e_cnt < next_decide - 1) || (exp_q.size() > 0) || m_pend);
    if (prev_rs && !read_state) bus_seen.push_back(main_bus);
    prev_rs = read_state;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic         wv;
    logic [W-1:0] wd;
    logic         rr;
    logic [W-1:0] ext;
    logic         x_rs;
    logic [W-1:0] x_cpu;
    logic         x_rdv;
    logic [W-1:0] x_rdd;
    logic         x_wrr;
    logic         x_rdr;
    logic         x_busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // single write 0xA: cpu_bus after E+1, read_state low two cycles from E+2
    vecs.push_back(vec_t'{1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0});
    // write 0x3 then read; bus released shows 0x6
    vecs.push_back(vec_t'{1'b1, 4'h3, 1'b0, 4'h6, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b1, 4'h6, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 4'h3, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 4'h3, 1'b0, 4'h6, 1'b1, 1'b1, 1'b0});
    // write 0xC and read on the same edge; extra rd_req while pending and
    // on the clearing edge are ignored
    vecs.push_back(vec_t'{1'b1, 4'hC, 1'b1, 4'h9, 1'b1, 4'h3, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 4'hC, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h9, 1'b0, 4'hC, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 4'hC, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 4'hC, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 4'hC, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 4'hC, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 4'hC, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 4'hC, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 4'hC, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0});
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] fill_exp[$];
    int rdv_total;

    model_reset();
    prev_rs = 1'b1;
    repeat (2) @(negedge myclk);

    // reset values
    check("rst_read_state", read_state, 1'b1);
    check("rst_cpu_bus",    cpu_bus,    '0);
    check("rst_rd_valid",   rd_valid,   1'b0);
    check("rst_rd_data",    rd_data,    '0);
    check("rst_wr_ready",   wr_ready,   1'b1);
    check("rst_rd_ready",   rd_ready,   1'b1);
    check("rst_busy",       busy,       1'b0);
    reset = 1'b0;

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].ext);
      check($sformatf("vec%0d_read_state", i), read_state, vecs[i].x_rs);
      check($sformatf("vec%0d_cpu_bus", i),    cpu_bus,    vecs[i].x_cpu);
      check($sformatf("vec%0d_rd_valid", i),   rd_valid,   vecs[i].x_rdv);
      check($sformatf("vec%0d_rd_data", i),    rd_data,    vecs[i].x_rdd);
      check($sformatf("vec%0d_wr_ready", i),   wr_ready,   vecs[i].x_wrr);
      check($sformatf("vec%0d_rd_ready", i),   rd_ready,   vecs[i].x_rdr);
      check($sformatf("vec%0d_busy", i),       busy,       vecs[i].x_busy);
    end

    // fill: write 0 occupies the bus while 1..4 fill the FIFO; 5 is dropped
    bus_seen.delete();
    for (int v = 0; v < 6; v++) begin
      step(1'b1, W'(v), 1'b0, 4'h0);
      if (v == 4) check("fill_wr_ready_full", wr_ready, 1'b0);
    end
    check("fill_wr_ready_after_pop", wr_ready, 1'b1);
    repeat (25) step(1'b0, 4'h0, 1'b0, 4'h0);
    fill_exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    check("fill_bus_count", bus_seen.size(), fill_exp.size());
    for (int i = 0; i < fill_exp.size() && i < bus_seen.size(); i++)
      check($sformatf("fill_bus_%0d", i), bus_seen[i], fill_exp[i]);
    check("fill_idle_busy", busy, 1'b0);

    // reset in the middle of HOLD with two writes queued
    step(1'b1, 4'hA, 1'b0, 4'h0);
    step(1'b1, 4'hB, 1'b0, 4'h0);
    step(1'b1, 4'hC, 1'b0, 4'h0);
    check("rst6_in_hold", read_state, 1'b0);
    reset = 1'b1;
    #1;
    check("rst6_async_release", read_state, 1'b1);
    check("rst6_busy",          busy,       1'b0);
    check("rst6_cpu_bus",       cpu_bus,    '0);
    @(posedge myclk);
    @(negedge myclk);
    reset = 1'b0;
    model_reset();
    prev_rs = 1'b1;
    bus_seen.delete();
    repeat (12) step(1'b0, 4'h0, 1'b0, 4'h0);
    check("rst6_no_bus_cycles", bus_seen.size(), 0);
    check("rst6_busy_after",    busy,            1'b0);
`ifdef BUS_CYCLE_CTRL_STATS_EN
    check("rst6_wr_count", wr_count, 8'h00);
    check("rst6_rd_count", rd_count, 8'h00);
`endif

    // random traffic against the model
    rdv_total = 0;
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 55), W'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 8), W'($urandom_range(0, 15)));
      if (rd_valid) rdv_total++;
    end
    repeat (40) step(1'b0, 4'h0, 1'b0, W'($urandom_range(0, 15)));
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle",    busy,         1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
